// File: rtl/core_defs_pkg.sv
// Shared definitions for the 3-stage core: sequencer state encoding,
// bubble instruction and address width.
package core_defs_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned INSN_W = 32;

   // addi x0, x0, 0 -- loaded by stage registers when flushed
   localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_PEND  = 2'd2
   } pipe_state_e;

endpackage : core_defs_pkg

// File: rtl/pipe_ctrl_flush_timer.sv
// Loadable down-counter timing the post-redirect flush window; last_o
// flags the final cycle of the window.
module flush_timer #(
   parameter int unsigned CNT_W    = 2,
   parameter int unsigned LOAD_VAL = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic dec_i,
   output logic last_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CNT_W'(LOAD_VAL);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_o = (cnt_q == CNT_W'(1));

endmodule : flush_timer

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates EX/bus stalls and redirects, drives PC
// redirect and per-register hold/flush, times the post-redirect flush window.
module pipe_ctrl
   import core_defs_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned ADDR_W       = core_defs_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              jump_en_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              hold_ex_i,
   input  logic              hold_bus_i,
   output logic              redirect_o,
   output logic [ADDR_W-1:0] pc_addr_o,
   output logic              hold_pc_o,
   output logic              hold_if_id_o,
   output logic              hold_id_ex_o,
   output logic              flush_if_id_o,
   output logic              flush_id_ex_o,
   output logic              busy_o
);

   localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

   pipe_state_e       state_q, state_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

   logic tmr_load, tmr_dec, tmr_last;
   logic redirect_c, hold_pc_c, hold_if_id_c, hold_id_ex_c;
   logic flush_if_id_c, flush_id_ex_c;

   flush_timer #(
      .CNT_W    (CNT_W),
      .LOAD_VAL (FLUSH_CYCLES)
   ) u_flush_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (tmr_load),
      .dec_i  (tmr_dec),
      .last_o (tmr_last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         pend_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         pend_addr_q <= pend_addr_d;
      end
   end

   // Next-state and raw control decode
   always_comb begin
      state_d       = state_q;
      pend_addr_d   = pend_addr_q;
      tmr_load      = 1'b0;
      tmr_dec       = 1'b0;
      redirect_c    = 1'b0;
      hold_pc_c     = 1'b0;
      hold_if_id_c  = 1'b0;
      hold_id_ex_c  = 1'b0;
      flush_if_id_c = 1'b0;
      flush_id_ex_c = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (hold_ex_i) begin
               hold_pc_c    = 1'b1;
               hold_if_id_c = 1'b1;
               hold_id_ex_c = 1'b1;
            end else if (jump_en_i && !hold_bus_i) begin
               redirect_c    = 1'b1;
               flush_if_id_c = 1'b1;
               flush_id_ex_c = 1'b1;
               tmr_load      = 1'b1;
               state_d       = ST_FLUSH;
            end else if (jump_en_i) begin
               pend_addr_d   = jump_addr_i;
               hold_pc_c     = 1'b1;
               flush_if_id_c = 1'b1;
               flush_id_ex_c = 1'b1;
               state_d       = ST_PEND;
            end else if (hold_bus_i) begin
               hold_pc_c     = 1'b1;
               flush_if_id_c = 1'b1;
            end
         end

         ST_FLUSH: begin
            flush_if_id_c = 1'b1;
            tmr_dec       = 1'b1;
            hold_pc_c     = hold_ex_i | hold_bus_i;
            hold_id_ex_c  = hold_ex_i;
            if (tmr_last) begin
               state_d = ST_IDLE;
            end
         end

         ST_PEND: begin
            hold_pc_c     = 1'b1;
            flush_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
            if (!hold_bus_i) begin
               redirect_c = 1'b1;
               tmr_load   = 1'b1;
               state_d    = ST_FLUSH;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are quiet while reset is asserted; flush beats hold on a register
   always_comb begin
      redirect_o    = rst_n & redirect_c;
      hold_pc_o     = rst_n & hold_pc_c;
      hold_if_id_o  = rst_n & hold_if_id_c & ~flush_if_id_c;
      hold_id_ex_o  = rst_n & hold_id_ex_c & ~flush_id_ex_c;
      flush_if_id_o = rst_n & flush_if_id_c;
      flush_id_ex_o = rst_n & flush_id_ex_c;
      busy_o        = rst_n & (state_q != ST_IDLE);
      pc_addr_o     = '0;
      if (rst_n) begin
         pc_addr_o = (state_q == ST_IDLE) ? jump_addr_i : pend_addr_q;
      end
   end

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random traffic,
// all checked against a behavioural model of the sequencing rules.
module tb_pipe_ctrl;

   localparam int unsigned FC = 2;
   localparam int unsigned AW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          jump_en_i;
   logic [AW-1:0] jump_addr_i;
   logic          hold_ex_i;
   logic          hold_bus_i;
   logic          redirect_o;
   logic [AW-1:0] pc_addr_o;
   logic          hold_pc_o, hold_if_id_o, hold_id_ex_o;
   logic          flush_if_id_o, flush_id_ex_o, busy_o;

   int tests  = 0;
   int fails  = 0;

   // Behavioural model: remaining flush cycles and a deferred jump
   int          m_flush_left;
   bit          m_pending;
   logic [AW-1:0] m_pend_addr;
   bit          saw_300;

   always #5 clk = ~clk;

   pipe_ctrl #(.FLUSH_CYCLES(FC), .ADDR_W(AW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .jump_en_i     (jump_en_i),
      .jump_addr_i   (jump_addr_i),
      .hold_ex_i     (hold_ex_i),
      .hold_bus_i    (hold_bus_i),
      .redirect_o    (redirect_o),
      .pc_addr_o     (pc_addr_o),
      .hold_pc_o     (hold_pc_o),
      .hold_if_id_o  (hold_if_id_o),
      .hold_id_ex_o  (hold_id_ex_o),
      .flush_if_id_o (flush_if_id_o),
      .flush_id_ex_o (flush_id_ex_o),
      .busy_o        (busy_o)
   );

   // Apply one cycle of inputs, compare against the model, advance the model
   task automatic step(input string tag, input bit rst, input bit jmp,
                       input logic [AW-1:0] addr, input bit ex, input bit bus);
      bit e_red, e_hpc, e_hifid, e_hidex, e_fifid, e_fidex, e_busy;
      logic [AW-1:0] e_addr;
      logic [AW+6:0] exp_v, obs_v;
      @(negedge clk);
      rst_n = rst; jump_en_i = jmp; jump_addr_i = addr;
      hold_ex_i = ex; hold_bus_i = bus;
      #1;
      e_red = 0; e_hpc = 0; e_hifid = 0; e_hidex = 0; e_fifid = 0; e_fidex = 0;
      e_addr = '0;
      e_busy = rst && (m_pending || m_flush_left > 0);
      if (!rst) begin
         m_pending = 0; m_flush_left = 0; m_pend_addr = '0;
      end else if (m_pending) begin
         e_hpc = 1; e_fifid = 1; e_fidex = 1; e_addr = m_pend_addr;
         if (!bus) begin
            e_red = 1; m_pending = 0; m_flush_left = FC;
         end
      end else if (m_flush_left > 0) begin
         e_fifid = 1; e_hpc = ex | bus; e_hidex = ex; e_addr = m_pend_addr;
         m_flush_left--;
      end else begin
         e_addr = addr;
         if (ex) begin
            e_hpc = 1; e_hifid = 1; e_hidex = 1;
         end else if (jmp && !bus) begin
            e_red = 1; e_fifid = 1; e_fidex = 1; m_flush_left = FC;
         end else if (jmp) begin
            e_hpc = 1; e_fifid = 1; e_fidex = 1;
            m_pending = 1; m_pend_addr = addr;
         end else if (bus) begin
            e_hpc = 1; e_fifid = 1;
         end
      end
      // Address only matters when a redirect is issued
      if (!e_red) e_addr = e_red ? e_addr : pc_addr_o;
      exp_v = {e_red, e_addr, e_hpc, e_hifid, e_hidex, e_fifid, e_fidex, e_busy};
      obs_v = {redirect_o, pc_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
               flush_if_id_o, flush_id_ex_o, busy_o};
      if (redirect_o && pc_addr_o == 32'h300) saw_300 = 1;
      tests++;
      assert (obs_v === exp_v) else begin
         fails++;
         $error("FAIL %s: observed red=%0b addr=%h hpc=%0b hifid=%0b hidex=%0b fifid=%0b fidex=%0b busy=%0b expected %h",
                tag, redirect_o, pc_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
                flush_if_id_o, flush_id_ex_o, busy_o, exp_v);
      end
   endtask

   initial begin
      m_flush_left = 0; m_pending = 0; m_pend_addr = '0; saw_300 = 0;
      rst_n = 0; jump_en_i = 1; jump_addr_i = 32'h40; hold_ex_i = 0; hold_bus_i = 0;
      @(posedge clk);

      // Reset with a jump request present
      step("reset0", 0, 1, 32'h40, 0, 0);
      step("reset1", 0, 1, 32'h40, 0, 0);
      step("idle0", 1, 0, 32'h0, 0, 0);
      step("idle1", 1, 0, 32'h0, 0, 0);

      // Plain jump and flush window
      step("jmp_T",  1, 1, 32'h100, 0, 0);
      step("jmp_T1", 1, 0, 32'h0, 0, 0);
      step("jmp_T2", 1, 0, 32'h0, 0, 0);
      step("jmp_T3", 1, 0, 32'h0, 0, 0);

      // Jump during bus stall
      step("pend_T",  1, 1, 32'h200, 0, 1);
      step("pend_T1", 1, 0, 32'h0, 0, 1);
      step("pend_T2", 1, 0, 32'h0, 1, 1);
      step("pend_T3", 1, 0, 32'h0, 0, 1);
      step("pend_T4", 1, 0, 32'h0, 0, 0);
      step("pend_T5", 1, 0, 32'h0, 1, 0);
      step("pend_T6", 1, 0, 32'h0, 0, 1);
      step("pend_T7", 1, 0, 32'h0, 0, 0);

      // EX busy blocks jump, then jump goes through
      step("exblk_T",  1, 1, 32'h180, 1, 0);
      step("exblk_T1", 1, 1, 32'h180, 0, 0);
      step("exblk_T2", 1, 0, 32'h0, 0, 0);
      step("exblk_T3", 1, 0, 32'h0, 0, 0);

      // Bus stall alone
      for (int i = 0; i < 3; i++) step("bus_only", 1, 0, 32'h0, 0, 1);

      // Reset mid-PEND drops the deferred jump
      saw_300 = 0;
      step("rp_enter", 1, 1, 32'h300, 0, 1);
      step("rp_hold",  1, 0, 32'h0, 0, 1);
      step("rp_rst",   0, 0, 32'h0, 0, 1);
      step("rp_rel",   1, 0, 32'h0, 0, 1);
      for (int i = 0; i < 4; i++) step("rp_after", 1, 0, 32'h0, 0, 0);
      tests++;
      assert (saw_300 == 0) else begin
         fails++;
         $error("FAIL rp_no_redirect: observed redirect to 0x300 expected none");
      end

      // Reset mid-FLUSH
      step("rf_jmp", 1, 1, 32'h500, 0, 0);
      step("rf_rst", 0, 0, 32'h0, 0, 0);
      step("rf_idl", 1, 0, 32'h0, 0, 0);

      // Random traffic; jump never offered while a flush window is open
      for (int i = 0; i < 600; i++) begin
         bit r, j, e, b;
         r = ($urandom_range(99) >= 2);
         e = ($urandom_range(99) < 20);
         b = ($urandom_range(99) < 30);
         j = ($urandom_range(99) < 30) && !(m_flush_left > 0 && !m_pending);
         step("random", r, j, AW'($urandom), e, b);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule : tb_pipe_ctrl
